// File: rtl/grf_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// grf_rd_arbiter_if
// Bundles the request, response and GRF read-mux signals of the register-file
// read-port arbiter.
//   req_valid/req_addr/req_ready : per-requester read request handshake
//   req_lock                     : per-requester lock hint (GRF_ARB_LOCK_EN only)
//   rf_raddr/rf_rdata            : select to / data from the 32:1 GRF read mux
//   rsp_valid/rsp_id/rsp_data    : registered read response
//   rsp_ready                    : response consumed
// Modports: slave = arbiter side, master = requester/environment side.
// Optional feature macro: GRF_ARB_LOCK_EN
// -----------------------------------------------------------------------------
interface grf_rd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
`ifdef GRF_ARB_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif
  logic [AW-1:0]      rf_raddr;
  logic [DW-1:0]      rf_rdata;
  logic               rsp_valid;
  logic [2:0]         rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_ready;

`ifdef GRF_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_addr, req_lock, rf_rdata, rsp_ready,
    output req_ready, rf_raddr, rsp_valid, rsp_id, rsp_data
  );
  modport master (
    output req_valid, req_addr, req_lock, rf_rdata, rsp_ready,
    input  req_ready, rf_raddr, rsp_valid, rsp_id, rsp_data
  );
`else
  modport slave (
    input  req_valid, req_addr, rf_rdata, rsp_ready,
    output req_ready, rf_raddr, rsp_valid, rsp_id, rsp_data
  );
  modport master (
    output req_valid, req_addr, rf_rdata, rsp_ready,
    input  req_ready, rf_raddr, rsp_valid, rsp_id, rsp_data
  );
`endif
endinterface

// File: rtl/grf_rd_arbiter.sv
// -----------------------------------------------------------------------------
// grf_rd_arbiter
// Round-robin arbiter sharing the single GRF read port among NREQ requesters.
// The winning address drives the read mux combinationally in the grant cycle;
// the returned data is registered one cycle later as the response, with reads
// of register 0 forced to zero.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : grf_rd_arbiter_if.slave (request, response and read-mux signals)
// Optional feature macro: GRF_ARB_LOCK_EN
//   When defined, a granted requester asserting req_lock keeps ownership of the
//   read port on its following valid requests until it issues with req_lock=0
//   or drops req_valid in a cycle where a grant could be made.
// -----------------------------------------------------------------------------
module grf_rd_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input logic              clk,
  input logic              reset,
  grf_rd_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NREQ);

  // Registered state
  logic          rsp_valid_q, rsp_valid_d;
  logic [2:0]    rsp_id_q,    rsp_id_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;
  logic [PW-1:0] ptr_q,       ptr_d;
  logic [AW-1:0] raddr_q,     raddr_d;
`ifdef GRF_ARB_LOCK_EN
  logic          lock_q,      lock_d;
  logic [PW-1:0] lock_idx_q,  lock_idx_d;
`endif

  // Arbitration results
  logic          can_issue_s;
  logic          found_s;
  logic [PW-1:0] cand_s;
  logic [PW-1:0] gnt_idx_s;
  logic          gnt_valid_s;
  logic [AW-1:0] gnt_addr_s;
  logic [PW-1:0] ptr_inc_s;
  logic [NREQ-1:0] req_ready_s;

  // Rotating priority scan from ptr, with a locked owner taking precedence.
  always_comb begin
    can_issue_s = !rsp_valid_q || bus.rsp_ready;
    found_s     = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
`ifdef GRF_ARB_LOCK_EN
    if (lock_q && bus.req_valid[lock_idx_q]) begin
      found_s   = 1'b1;
      gnt_idx_s = lock_idx_q;
    end else begin
      found_s   = 1'b0;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      cand_s = PW'((int'(ptr_q) + k) % NREQ);
      if (!found_s && bus.req_valid[cand_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        found_s   = found_s;
      end
    end
    gnt_valid_s = can_issue_s && found_s;
    gnt_addr_s  = bus.req_addr[int'(gnt_idx_s)*AW +: AW];
    ptr_inc_s   = (gnt_idx_s == PW'(NREQ - 1)) ? '0 : gnt_idx_s + PW'(1);
    req_ready_s = '0;
    if (gnt_valid_s) begin
      req_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Next-state: issue, drain on consume, or freeze under backpressure.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    ptr_d       = ptr_q;
    raddr_d     = raddr_q;
`ifdef GRF_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (gnt_valid_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = 3'(gnt_idx_s);
      rsp_data_d  = (gnt_addr_s == '0) ? '0 : bus.rf_rdata;
      raddr_d     = gnt_addr_s;
`ifdef GRF_ARB_LOCK_EN
      if (bus.req_lock[gnt_idx_s]) begin
        // Owner keeps the port; ptr stays so normal order resumes after it.
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx_s;
        ptr_d      = ptr_q;
      end else begin
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_inc_s;
      end
`else
      ptr_d       = ptr_inc_s;
`endif
    end else if (can_issue_s) begin
      // No requester at all: any lock owner has dropped valid.
      rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
`ifdef GRF_ARB_LOCK_EN
      lock_d      = 1'b0;
`endif
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 3'd0;
      rsp_data_q  <= '0;
      ptr_q       <= '0;
      raddr_q     <= '0;
`ifdef GRF_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      ptr_q       <= ptr_d;
      raddr_q     <= raddr_d;
`ifdef GRF_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  // Mux select follows the grant, otherwise holds the last issued address.
  assign bus.rf_raddr  = gnt_valid_s ? gnt_addr_s : raddr_q;
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_grf_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grf_rd_arbiter
// Directed bench for grf_rd_arbiter with a small register-file model behind
// the read mux. Inputs change #1 after the rising edge; combinational outputs
// are checked at the falling edge, registered outputs #1 after the next rise.
// Optional feature macro: GRF_ARB_LOCK_EN (enables the lock scenario).
// -----------------------------------------------------------------------------
module tb_grf_rd_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk;
  logic reset;
  logic force_ones;
  logic [DW-1:0] rf_mem [32];
  int n_cmp;
  int n_err;

  grf_rd_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  grf_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Register-file read mux model (combinational from rf_raddr).
  assign bus.rf_rdata = force_ones ? 32'hFFFF_FFFF : rf_mem[bus.rf_raddr];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  // Advance to #1 after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the falling edge so combinational outputs have settled.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    force_ones = 1'b0;
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000_0000 + r;
    rf_mem[8] = 32'hDEAD_BEEF;
    bus.req_valid = 4'b0000;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b1;
`ifdef GRF_ARB_LOCK_EN
    bus.req_lock  = 4'b0000;
`endif
    reset = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_id",    {29'd0, bus.rsp_id},    32'd0);
    check("rst_rsp_data",  bus.rsp_data,           32'd0);
    check("rst_rf_raddr",  {27'd0, bus.rf_raddr},  32'd0);

    // Single request from 0 to register 8
    bus.req_valid = 4'b0001;
    set_addr(0, 5'd8);
    mid();
    check("single_ready", {28'd0, bus.req_ready}, 32'h1);
    check("single_raddr", {27'd0, bus.rf_raddr},  32'd8);
    tick();
    bus.req_valid = 4'b0000;
    check("single_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("single_id",    {29'd0, bus.rsp_id},    32'd0);
    check("single_data",  bus.rsp_data,           32'hDEAD_BEEF);

    // Round-robin fairness from ptr=0; requester i reads register i+1
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_addr(i, 5'(i + 1));
    for (int k = 0; k < 6; k++) begin
      mid();
      check($sformatf("rr_ready_%0d", k), {28'd0, bus.req_ready}, 32'(1 << (k % 4)));
      tick();
      check($sformatf("rr_valid_%0d", k), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("rr_id_%0d", k),    {29'd0, bus.rsp_id},    32'(k % 4));
      check($sformatf("rr_data_%0d", k),  bus.rsp_data,           32'h1000_0000 + 32'((k % 4) + 1));
    end

    // Backpressure: last response came from requester 1 (register 2)
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check($sformatf("bp_ready_%0d", k), {28'd0, bus.req_ready}, 32'd0);
      check($sformatf("bp_raddr_%0d", k), {27'd0, bus.rf_raddr},  32'd2);
      tick();
      check($sformatf("bp_valid_%0d", k), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("bp_id_%0d", k),    {29'd0, bus.rsp_id},    32'd1);
      check($sformatf("bp_data_%0d", k),  bus.rsp_data,           32'h1000_0002);
    end
    bus.rsp_ready = 1'b1;
    mid();
    check("bp_rel_ready", {28'd0, bus.req_ready}, 32'h4);
    tick();
    check("bp_rel_id",   {29'd0, bus.rsp_id}, 32'd2);
    check("bp_rel_data", bus.rsp_data,        32'h1000_0003);

    // $zero read by requester 3 with the mux returning all ones
    bus.req_valid = 4'b1000;
    set_addr(3, 5'd0);
    force_ones = 1'b1;
    mid();
    check("zero_ready", {28'd0, bus.req_ready}, 32'h8);
    check("zero_raddr", {27'd0, bus.rf_raddr},  32'd0);
    tick();
    check("zero_id",   {29'd0, bus.rsp_id}, 32'd3);
    check("zero_data", bus.rsp_data,        32'd0);
    force_ones = 1'b0;

    // Idle with consume: response drains, mux select holds
    bus.req_valid = 4'b0000;
    tick();
    check("drain_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("drain_raddr", {27'd0, bus.rf_raddr},  32'd0);

    // Mid-stream reset with rsp_valid=1 and ptr=2 (ptr is 0 here)
    bus.req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_addr(i, 5'(i + 1));
    tick();
    tick();
    check("pre_rst_id", {29'd0, bus.rsp_id}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1110;
    check("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_data",  bus.rsp_data,           32'd0);
    mid();
    check("mid_rst_ready", {28'd0, bus.req_ready}, 32'h2);
    tick();
    check("mid_rst_id", {29'd0, bus.rsp_id}, 32'd1);

`ifdef GRF_ARB_LOCK_EN
    // Lock: bring ptr to 1, then requester 1 locked for its first two reads
    do_reset();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      bus.req_lock = (k < 2) ? 4'b0010 : 4'b0000;
      mid();
      check($sformatf("lock_ready_%0d", k), {28'd0, bus.req_ready}, 32'h2);
      tick();
      check($sformatf("lock_id_%0d", k), {29'd0, bus.rsp_id}, 32'd1);
    end
    bus.req_lock  = 4'b0000;
    bus.req_valid = 4'b0101;
    mid();
    check("unlock_ready_0", {28'd0, bus.req_ready}, 32'h4);
    tick();
    mid();
    check("unlock_ready_1", {28'd0, bus.req_ready}, 32'h1);
    tick();
    check("unlock_id_1", {29'd0, bus.rsp_id}, 32'd0);
`endif

    bus.req_valid = 4'b0000;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
